tug_referee: RTL

- Scoring and round-control block at the consumer end of the tug-of-war playfield's light bus.
- Watches the nine-light playfield vector together with the same L/R press pulses that drive the playfield, and detects when a player pushes the lit light off their end.
- Keeps per-player scores and drives two 7-segment digits.
- Pulses a round reset that recentres the playfield, and ends the match at MAX_SCORE.

---
 rtl/tug_referee_if.sv | 22 ++
 rtl/tug_referee.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/tug_referee_if.sv
// Light-bus and scoreboard signals between the playfield/top level and the tug-of-war referee.
// master drives presses and lights; slave (the referee) returns scores, round_reset and match status.
interface tug_referee_if;
    logic       L;
    logic       R;
    logic [9:1] LEDR;
    logic       round_reset;
    logic [6:0] HEX0;
    logic [6:0] HEX1;
    logic [1:0] winner;
    logic       game_over;

    modport master (
        output L, R, LEDR,
        input  round_reset, HEX0, HEX1, winner, game_over
    );

    modport slave (
        input  L, R, LEDR,
        output round_reset, HEX0, HEX1, winner, game_over
    );
endinterface

// File: rtl/tug_referee.sv
// Tug-of-war referee: scores end-light pushes, drives two HEX digits and round_reset; L&R restart in GAMEOVER under TUG_REFEREE_RESTART_EN.
// Outputs registered one cycle behind the state; no backpressure, presses outside PLAY are dropped.
module tug_referee #(
    parameter int MAX_SCORE   = 7,
    parameter int HOLD_CYCLES = 4
) (
    input  logic          clk,
    input  logic          reset,
    tug_referee_if.slave  bus
);

    localparam logic [2:0]    MAX_S     = 3'(MAX_SCORE);
    localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_CYCLES - 1);
    localparam logic [6:0]    SEG_ZERO  = 7'b1000000;

    typedef enum logic [1:0] {
        ST_PLAY,
        ST_SCORE,
        ST_HOLD,
        ST_GAMEOVER
    } state_t;

    state_t        r_state,   w_state_nxt;
    logic [2:0]    r_score_l, w_score_l_nxt;
    logic [2:0]    r_score_r, w_score_r_nxt;
    logic [HW-1:0] r_hold_cnt, w_hold_cnt_nxt;
    logic          w_restart;
    logic          w_left_pt;
    logic          w_right_pt;
    logic          w_at_max;

    logic          r_round_reset;
    logic [6:0]    r_hex0;
    logic [6:0]    r_hex1;
    logic [1:0]    r_winner;
    logic          r_game_over;

    function automatic logic [6:0] f_seg7(input logic [2:0] v);
        logic [6:0] seg;
        case (v)
            3'd0:    seg = 7'b1000000;
            3'd1:    seg = 7'b1111001;
            3'd2:    seg = 7'b0100100;
            3'd3:    seg = 7'b0110000;
            3'd4:    seg = 7'b0011001;
            3'd5:    seg = 7'b0010010;
            3'd6:    seg = 7'b0000010;
            default: seg = 7'b1111000;
        endcase
        return seg;
    endfunction

    // Both ends lit with one press still yields a single point: L&~R and R&~L cannot both hold.
    assign w_left_pt  = bus.LEDR[9] & bus.L & ~bus.R;
    assign w_right_pt = bus.LEDR[1] & bus.R & ~bus.L;
    assign w_at_max   = (r_score_l == MAX_S) || (r_score_r == MAX_S);

    always_comb begin
        w_state_nxt    = r_state;
        w_score_l_nxt  = r_score_l;
        w_score_r_nxt  = r_score_r;
        w_hold_cnt_nxt = r_hold_cnt;
        w_restart      = 1'b0;
        case (r_state)
            ST_PLAY: begin
                if (w_left_pt) begin
                    w_score_l_nxt = r_score_l + 3'd1;
                    w_state_nxt   = ST_SCORE;
                end else if (w_right_pt) begin
                    w_score_r_nxt = r_score_r + 3'd1;
                    w_state_nxt   = ST_SCORE;
                end
            end
            ST_SCORE: begin
                if (w_at_max) begin
                    w_state_nxt = ST_GAMEOVER;
                end else begin
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (r_hold_cnt == '0) begin
                    w_state_nxt = ST_PLAY;
                end else begin
                    w_hold_cnt_nxt = r_hold_cnt - 1'b1;
                end
            end
            ST_GAMEOVER: begin
`ifdef TUG_REFEREE_RESTART_EN
                if (bus.L && bus.R) begin
                    w_restart      = 1'b1;
                    w_score_l_nxt  = 3'd0;
                    w_score_r_nxt  = 3'd0;
                    w_state_nxt    = ST_HOLD;
                    w_hold_cnt_nxt = HOLD_LOAD;
                end
`endif
            end
            default: w_state_nxt = ST_PLAY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_PLAY;
            r_score_l  <= 3'd0;
            r_score_r  <= 3'd0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_score_l  <= w_score_l_nxt;
            r_score_r  <= w_score_r_nxt;
            r_hold_cnt <= w_hold_cnt_nxt;
        end
    end

    // Reset and restart clear the display on the same edge; otherwise outputs trail the state by one cycle.
    always_ff @(posedge clk) begin
        if (!reset || w_restart) begin
            r_round_reset <= 1'b1;
            r_hex0        <= SEG_ZERO;
            r_hex1        <= SEG_ZERO;
            r_winner      <= 2'b00;
            r_game_over   <= 1'b0;
        end else begin
            r_round_reset <= (r_state == ST_SCORE);
            r_hex0        <= f_seg7(r_score_r);
            r_hex1        <= f_seg7(r_score_l);
            r_game_over   <= (r_state == ST_GAMEOVER);
            if (r_state == ST_GAMEOVER) begin
                r_winner <= (r_score_l == MAX_S) ? 2'b10 : 2'b01;
            end else begin
                r_winner <= 2'b00;
            end
        end
    end

    assign bus.round_reset = r_round_reset;
    assign bus.HEX0        = r_hex0;
    assign bus.HEX1        = r_hex1;
    assign bus.winner      = r_winner;
    assign bus.game_over   = r_game_over;

endmodule
